// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
package prog_loader_pkg;

   localparam int PL_MAX_WORD_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_COMMIT,
      ST_FULL
   } pl_state_t;

endpackage

// File: rtl/prog_loader_strobe_edge.sv
// Rising-edge detector for the pad-level byte write strobe.
module strobe_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= 1'b0;
      else     r_q <= d;
   end

   assign rise = d & ~r_q;

endmodule

// File: rtl/prog_loader.sv
// Assembles strobed bytes into little-endian words and writes them to a local memory.
// Optional running byte checksum: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter  int WORD_BYTES = 4,
   parameter  int DEPTH      = 16,
   parameter  int WRAP       = 0,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    we_i,
   input  logic [7:0]              data_i,
   input  logic                    clr_i,
   input  logic [AW-1:0]           rd_addr_i,
   output logic [8*WORD_BYTES-1:0] rd_data_o,
   output logic [AW-1:0]           wr_ptr_o,
   output logic [1:0]              byte_idx_o,
   output logic                    word_valid_o,
   output logic                    full_o,
   output logic                    overflow_o,
   output logic [7:0]              checksum_o
);

   localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

   pl_state_t               r_state, w_next;
   logic                    w_rise, w_acc, w_take, w_ovf, w_wr, w_to_full;
   logic [1:0]              r_byte_idx, w_lane;
   logic [AW-1:0]           r_wr_ptr;
   logic [8*WORD_BYTES-1:0] r_asm, r_rd;
   logic                    r_wv, r_ovf;
   logic [8*WORD_BYTES-1:0] r_mem [DEPTH];

   strobe_edge u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (we_i),
      .rise (w_rise)
   );

   assign w_acc     = ena & w_rise;
   assign w_to_full = (r_wr_ptr == AW'(DEPTH - 1)) && (WRAP == 0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // A byte arriving during COMMIT starts the next word in lane 0.
   always_comb begin
      w_next = r_state;
      w_lane = r_byte_idx;
      w_take = 1'b0;
      w_ovf  = 1'b0;
      w_wr   = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_FILL: begin
            if (w_acc) begin
               w_take = 1'b1;
               w_next = (r_byte_idx == LAST) ? ST_COMMIT : ST_FILL;
            end
         end
         ST_COMMIT: begin
            w_wr   = 1'b1;
            w_lane = 2'd0;
            w_next = w_to_full ? ST_FULL : ST_IDLE;
            if (w_acc) begin
               if (w_to_full) begin
                  w_ovf = 1'b1;
               end else begin
                  w_take = 1'b1;
                  w_next = (LAST == 2'd0) ? ST_COMMIT : ST_FILL;
               end
            end
         end
         ST_FULL: w_ovf = w_acc;
      endcase
      if (clr_i) begin
         w_next = ST_IDLE;
         w_take = 1'b0;
         w_ovf  = 1'b0;
         w_wr   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_byte_idx <= '0;
         r_asm      <= '0;
         r_rd       <= '0;
         r_wv       <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_wv <= w_wr;
         r_rd <= r_mem[rd_addr_i];
         if (clr_i) begin
            r_wr_ptr   <= '0;
            r_byte_idx <= '0;
            r_ovf      <= 1'b0;
         end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_take)
               r_byte_idx <= (w_lane == LAST) ? 2'd0 : w_lane + 2'd1;
            else if (w_wr)
               r_byte_idx <= 2'd0;
            if (w_ovf) r_ovf <= 1'b1;
         end
         for (int i = 0; i < WORD_BYTES; i++)
            if (w_take && w_lane == 2'(i)) r_asm[i*8 +: 8] <= data_i;
      end
   end

   // No reset on the array: contents survive rst and clr_i.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_asm;
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_csum <= '0;
      else if (clr_i)  r_csum <= '0;
      else if (w_take) r_csum <= r_csum + data_i;
   end

   assign checksum_o = r_csum;
`else
   assign checksum_o = 8'h00;
`endif

   assign rd_data_o    = r_rd;
   assign wr_ptr_o     = r_wr_ptr;
   assign byte_idx_o   = r_byte_idx;
   assign word_valid_o = r_wv;
   assign full_o       = (r_state == ST_FULL);
   assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default build plus DEPTH=4 instances with and without wrap.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst, ena, we_i, clr_i;
   logic [7:0] data_i;
   logic [3:0] rd_addr;

   logic [31:0] rd0, rd1, rd2;
   logic [3:0]  ptr0;
   logic [1:0]  ptr1, ptr2, idx0, idx1, idx2;
   logic        wv0, wv1, wv2, full0, full1, full2, ovf0, ovf1, ovf2;
   logic [7:0]  cs0, cs1, cs2;

   int n_assert = 0;
   int n_fail   = 0;
   int wv_cnt   = 0;
   logic [31:0] sb_q[$];

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam logic [7:0] CS_A = 8'h42;
   localparam logic [7:0] CS_B = 8'h46;
`else
   localparam logic [7:0] CS_A = 8'h00;
   localparam logic [7:0] CS_B = 8'h00;
`endif

   always #5 clk = ~clk;

   prog_loader u_dut (
      .clk(clk), .rst(rst), .ena(ena), .we_i(we_i), .data_i(data_i),
      .clr_i(clr_i), .rd_addr_i(rd_addr), .rd_data_o(rd0),
      .wr_ptr_o(ptr0), .byte_idx_o(idx0), .word_valid_o(wv0),
      .full_o(full0), .overflow_o(ovf0), .checksum_o(cs0)
   );

   prog_loader #(.DEPTH(4), .WRAP(0)) u_d4 (
      .clk(clk), .rst(rst), .ena(ena), .we_i(we_i), .data_i(data_i),
      .clr_i(clr_i), .rd_addr_i(rd_addr[1:0]), .rd_data_o(rd1),
      .wr_ptr_o(ptr1), .byte_idx_o(idx1), .word_valid_o(wv1),
      .full_o(full1), .overflow_o(ovf1), .checksum_o(cs1)
   );

   prog_loader #(.DEPTH(4), .WRAP(1)) u_w4 (
      .clk(clk), .rst(rst), .ena(ena), .we_i(we_i), .data_i(data_i),
      .clr_i(clr_i), .rd_addr_i(rd_addr[1:0]), .rd_data_o(rd2),
      .wr_ptr_o(ptr2), .byte_idx_o(idx2), .word_valid_o(wv2),
      .full_o(full2), .overflow_o(ovf2), .checksum_o(cs2)
   );

   always @(negedge clk) if (wv0) wv_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_i = b;
      we_i   = 1'b1;
      @(posedge clk); #1;
      we_i   = 1'b0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      @(posedge clk); #1;
      clr_i = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int sel, input logic [3:0] a);
      logic [31:0] obs, exp;
      rd_addr = a;
      @(posedge clk); #1;
      obs = (sel == 0) ? rd0 : (sel == 1) ? rd1 : rd2;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb_q.pop_front();
         chk(tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; ena = 1'b1; we_i = 1'b0; clr_i = 1'b0;
      data_i = 8'h00; rd_addr = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd",   rd0, 32'h0);
      chk("rst_ptr",  32'(ptr0), 32'h0);
      chk("rst_idx",  32'(idx0), 32'h0);
      chk("rst_wv",   32'(wv0), 32'h0);
      chk("rst_full", 32'(full0), 32'h0);
      chk("rst_ovf",  32'(ovf0), 32'h0);
      chk("rst_cs",   32'(cs0), 32'h0);
      rst = 1'b0;

      // twelve single-cycle strobes
      w = '0;
      for (int i = 0; i < 12; i++) begin
         send_byte(8'(i));
         w[(i%4)*8 +: 8] = 8'(i);
         if (i % 4 == 3) sb_q.push_back(w);
      end
      chk("s1_ptr", 32'(ptr0), 32'd3);
      chk("s1_wv",  32'(wv_cnt), 32'd3);
      chk("s1_cs",  32'(cs0), 32'(CS_A));
      rd_chk("s1_mem0", 0, 4'd0);
      rd_chk("s1_mem1", 0, 4'd1);
      rd_chk("s1_mem2", 0, 4'd2);

      // reset after six bytes
      pulse_clr();
      for (int i = 0; i < 6; i++) send_byte(8'(i));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("r_rd",   rd0, 32'h0);
      chk("r_ptr",  32'(ptr0), 32'h0);
      chk("r_idx",  32'(idx0), 32'h0);
      chk("r_full", 32'(full0), 32'h0);
      chk("r_ovf",  32'(ovf0), 32'h0);
      chk("r_cs",   32'(cs0), 32'h0);
      rst = 1'b0;
      sb_q.push_back(32'h03020100);
      rd_chk("r_mem0", 0, 4'd0);
      sb_q.push_back(32'h07060504);
      rd_chk("r_mem1", 0, 4'd1);

      // strobe held for five cycles
      data_i = 8'hA5;
      we_i   = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      we_i = 1'b0;
      @(posedge clk); #1;
      chk("hold_idx", 32'(idx0), 32'd1);

      // restart mid-word
      pulse_clr();
      send_byte(8'hEE);
      send_byte(8'hEF);
      pulse_clr();
      for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
      chk("clr_ptr", 32'(ptr0), 32'd1);
      chk("clr_cs",  32'(cs0), 32'(CS_B));
      sb_q.push_back(32'h13121110);
      rd_chk("clr_mem0", 0, 4'd0);

      // DEPTH=4 fill, overflow and wrap
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 15; i++) send_byte(8'h20 + 8'(i));
      chk("d4_full15", 32'(full1), 32'd0);
      send_byte(8'h2F);
      chk("d4_full16", 32'(full1), 32'd1);
      chk("d4_ovf16",  32'(ovf1), 32'd0);
      send_byte(8'h30);
      chk("d4_ovf17",  32'(ovf1), 32'd1);
      chk("d4_full17", 32'(full1), 32'd1);
      for (int i = 17; i < 20; i++) send_byte(8'h20 + 8'(i));
      chk("w4_full", 32'(full2), 32'd0);
      chk("w4_ovf",  32'(ovf2), 32'd0);
      chk("w4_ptr",  32'(ptr2), 32'd1);
      sb_q.push_back(32'h23222120);
      rd_chk("d4_mem0", 1, 4'd0);
      sb_q.push_back(32'h33323130);
      rd_chk("w4_mem0", 2, 4'd0);
      sb_q.push_back(32'h27262524);
      rd_chk("w4_mem1", 2, 4'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
